// File: rtl/adc_scan_pkg.sv
// Shared constants, FSM state type, channel map and small helpers for the ADC scan controller.
package adc_scan_pkg;

  localparam int NCH     = 18;
  localparam int DW      = 10;
  localparam int RST_CYC = 4;
  localparam int TRK_CYC = 8;
  localparam int SET_CYC = 4;
  localparam int CHW     = 5;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_RST,
    ST_TRK,
    ST_HLD,
    ST_BIT,
    ST_DONE
  } scan_state_e;

  localparam logic [CHW-1:0] CH_VIN20 = 5'd0;
  localparam logic [CHW-1:0] CH_VO10  = 5'd1;
  localparam logic [CHW-1:0] CH_IS    = 5'd2;
  localparam logic [CHW-1:0] CH_TS    = 5'd3;
  localparam logic [CHW-1:0] CH_DP    = 5'd4;
  localparam logic [CHW-1:0] CH_DN    = 5'd5;
  localparam logic [CHW-1:0] CH_CC1   = 5'd6;
  localparam logic [CHW-1:0] CH_CC2   = 5'd7;
  localparam logic [CHW-1:0] CH_DP3   = 5'd8;
  localparam logic [CHW-1:0] CH_DN3   = 5'd9;
  localparam logic [CHW-1:0] CH_VO20  = 5'd10;
  localparam logic [CHW-1:0] CH_CC1_4 = 5'd11;
  localparam logic [CHW-1:0] CH_CC2_4 = 5'd12;
  localparam logic [CHW-1:0] CH_GP5   = 5'd13;
  localparam logic [CHW-1:0] CH_GP4   = 5'd14;
  localparam logic [CHW-1:0] CH_GP3   = 5'd15;
  localparam logic [CHW-1:0] CH_GP2   = 5'd16;
  localparam logic [CHW-1:0] CH_GP1   = 5'd17;

  // First set bit of mask at or after rr, wrapping from NCH-1 back to 0.
  function automatic logic [CHW-1:0] next_ch(input logic [NCH-1:0] mask,
                                             input logic [CHW-1:0] rr);
    logic [CHW:0] idx;
    logic         found;
    next_ch = '0;
    found   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = {1'b0, rr} + (CHW+1)'(k);
      if (idx >= (CHW+1)'(NCH)) idx = idx - (CHW+1)'(NCH);
      if (!found && mask[idx[CHW-1:0]]) begin
        next_ch = idx[CHW-1:0];
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [CHW-1:0] ch);
    onehot = {{(NCH-1){1'b0}}, 1'b1} << ch;
  endfunction

endpackage

// File: rtl/adc_sar_step.sv
// Successive-approximation bit stepper: comparator synchronizer, per-bit settle timer and
// trial/keep logic. A start pulse loads the mid-scale trial; done pulses on the final decision.
module adc_sar_step
  import adc_scan_pkg::*;
(
  input  logic          clk,
  input  logic          srst,
  input  logic          start,
  input  logic          comp_i,
  output logic [DW-1:0] code,
  output logic [DW-1:0] result,
  output logic          done
);

  localparam int SW = 3;
  localparam int BW = 4;

  logic [DW-1:0] code_d, code_q;
  logic [BW-1:0] bit_d, bit_q;
  logic [SW-1:0] cnt_d, cnt_q;
  logic          active_d, active_q;
  logic          sync1_d, sync1_q;
  logic          sync2_d, sync2_q;

  // The first bit gets one extra settle cycle so it spans the hold cycle as well.
  always_comb begin
    code_d   = code_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    sync1_d  = comp_i;
    sync2_d  = sync1_q;
    done     = 1'b0;
    if (start) begin
      code_d   = {1'b1, {(DW-1){1'b0}}};
      bit_d    = BW'(DW-1);
      cnt_d    = SW'(SET_CYC);
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        if (!sync2_q) code_d[bit_q] = 1'b0;
        cnt_d = SW'(SET_CYC-1);
        if (bit_q == '0) begin
          active_d = 1'b0;
          done     = 1'b1;
        end else begin
          bit_d         = bit_q - 1'b1;
          code_d[bit_d] = 1'b1;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      code_q   <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
    end else begin
      code_q   <= code_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
    end
  end

  assign code   = code_q;
  assign result = code_d;

endmodule

// File: rtl/adc_scan_ctl.sv
// Scan sequencer/arbiter for the shared SAR comparator path: round-robin background scan with
// one-shot pre-emption between conversions. Define ADC_AVG_EN to average 4 conversions per selection.
module adc_scan_ctl
  import adc_scan_pkg::*;
(
  input  logic           clk,
  input  logic           srst,
  input  logic           scan_en,
  input  logic [NCH-1:0] ch_en,
  input  logic           req_vld,
  input  logic [4:0]     req_ch,
  output logic           req_ack,
  input  logic           comp_i,
  output logic [NCH-1:0] dac_sel,
  output logic           sh_rst,
  output logic           sh_hold,
  output logic           dac_en,
  output logic [DW-1:0]  dac_code,
  output logic           res_vld,
  output logic [4:0]     res_ch,
  output logic [DW-1:0]  res_dat,
  output logic           res_os,
  output logic           busy
);

  scan_state_e    state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CHW-1:0] ch_d, ch_q;
  logic [CHW-1:0] rr_d, rr_q;
  logic           os_d, os_q;
  logic           req_ack_d, req_ack_q;
  logic [NCH-1:0] dac_sel_d, dac_sel_q;
  logic           sh_rst_d, sh_rst_q;
  logic           sh_hold_d, sh_hold_q;
  logic           dac_en_d, dac_en_q;
  logic           res_vld_d, res_vld_q;
  logic [CHW-1:0] res_ch_d, res_ch_q;
  logic [DW-1:0]  res_dat_d, res_dat_q;
  logic           res_os_d, res_os_q;
  logic           busy_d, busy_q;
  logic           conv_last;

  logic           sar_start;
  logic           sar_done;
  logic [DW-1:0]  sar_result;

`ifdef ADC_AVG_EN
  localparam int NAVG  = 4;
  localparam int ACC_W = 12;

  logic [1:0]       avg_cnt_d, avg_cnt_q;
  logic [ACC_W-1:0] acc_d, acc_q;

  // Rounded mean of the four samples, clamped to full scale.
  function automatic logic [DW-1:0] avg_round(input logic [ACC_W-1:0] acc);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + (ACC_W+1)'(2);
    if (s[ACC_W:2] > (ACC_W-1)'((1 << DW) - 1)) avg_round = '1;
    else                                        avg_round = s[DW+1:2];
  endfunction
`endif

  adc_sar_step u_sar (
    .clk    (clk),
    .srst   (srst),
    .start  (sar_start),
    .comp_i (comp_i),
    .code   (dac_code),
    .result (sar_result),
    .done   (sar_done)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    rr_d      = rr_q;
    os_d      = os_q;
    req_ack_d = 1'b0;
    dac_sel_d = dac_sel_q;
    sh_rst_d  = sh_rst_q;
    sh_hold_d = sh_hold_q;
    dac_en_d  = dac_en_q;
    res_vld_d = 1'b0;
    res_ch_d  = res_ch_q;
    res_dat_d = res_dat_q;
    res_os_d  = res_os_q;
    sar_start = 1'b0;
    conv_last = 1'b0;
`ifdef ADC_AVG_EN
    avg_cnt_d = avg_cnt_q;
    acc_d     = acc_q;
`endif
    unique case (state_q)
      // A valid one-shot request always wins over the background scan.
      ST_IDLE: begin
        if (req_vld && (req_ch < CHW'(NCH))) begin
          ch_d      = req_ch;
          os_d      = 1'b1;
          req_ack_d = 1'b1;
          state_d   = ST_SEL;
        end else if (scan_en && (|ch_en)) begin
          ch_d    = next_ch(ch_en, rr_q);
          os_d    = 1'b0;
          state_d = ST_SEL;
        end
        if (state_d == ST_SEL) begin
          dac_sel_d = onehot(ch_d);
          dac_en_d  = 1'b1;
        end
`ifdef ADC_AVG_EN
        avg_cnt_d = '0;
        acc_d     = '0;
`endif
      end
      ST_SEL: begin
        state_d  = ST_RST;
        sh_rst_d = 1'b1;
        cnt_d    = '0;
      end
      ST_RST: begin
        if (cnt_q == CNT_W'(RST_CYC-1)) begin
          state_d  = ST_TRK;
          sh_rst_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_TRK: begin
        if (cnt_q == CNT_W'(TRK_CYC-1)) begin
          state_d   = ST_HLD;
          sh_hold_d = 1'b1;
          sar_start = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HLD: state_d = ST_BIT;
      ST_BIT: begin
        if (sar_done) begin
`ifdef ADC_AVG_EN
          acc_d = acc_q + ACC_W'(sar_result);
          if (avg_cnt_q == 2'(NAVG-1)) begin
            conv_last = 1'b1;
            res_dat_d = avg_round(acc_d);
          end else begin
            avg_cnt_d = avg_cnt_q + 1'b1;
            state_d   = ST_RST;
            sh_hold_d = 1'b0;
            sh_rst_d  = 1'b1;
            cnt_d     = '0;
          end
`else
          conv_last = 1'b1;
          res_dat_d = sar_result;
`endif
        end
        // Results post as the FSM enters DONE so they are visible for that one cycle.
        if (conv_last) begin
          state_d   = ST_DONE;
          res_vld_d = 1'b1;
          res_ch_d  = ch_q;
          res_os_d  = os_q;
          sh_hold_d = 1'b0;
          dac_en_d  = 1'b0;
          dac_sel_d = '0;
          if (!os_q) rr_d = (ch_q == CHW'(NCH-1)) ? '0 : ch_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ch_q      <= '0;
      rr_q      <= '0;
      os_q      <= 1'b0;
      req_ack_q <= 1'b0;
      dac_sel_q <= '0;
      sh_rst_q  <= 1'b0;
      sh_hold_q <= 1'b0;
      dac_en_q  <= 1'b0;
      res_vld_q <= 1'b0;
      res_ch_q  <= '0;
      res_dat_q <= '0;
      res_os_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ADC_AVG_EN
      avg_cnt_q <= '0;
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      rr_q      <= rr_d;
      os_q      <= os_d;
      req_ack_q <= req_ack_d;
      dac_sel_q <= dac_sel_d;
      sh_rst_q  <= sh_rst_d;
      sh_hold_q <= sh_hold_d;
      dac_en_q  <= dac_en_d;
      res_vld_q <= res_vld_d;
      res_ch_q  <= res_ch_d;
      res_dat_q <= res_dat_d;
      res_os_q  <= res_os_d;
      busy_q    <= busy_d;
`ifdef ADC_AVG_EN
      avg_cnt_q <= avg_cnt_d;
      acc_q     <= acc_d;
`endif
    end
  end

  assign req_ack = req_ack_q;
  assign dac_sel = dac_sel_q;
  assign sh_rst  = sh_rst_q;
  assign sh_hold = sh_hold_q;
  assign dac_en  = dac_en_q;
  assign res_vld = res_vld_q;
  assign res_ch  = res_ch_q;
  assign res_dat = res_dat_q;
  assign res_os  = res_os_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_adc_scan_ctl.sv
// Bench for adc_scan_ctl: analog comparator model on DAC1, channel/priority scoreboard and
// conversion timing model derived from the scan rules.
module tb_adc_scan_ctl;
  import adc_scan_pkg::*;

`ifdef ADC_AVG_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif
  localparam int CONV_CYC = RST_CYC + TRK_CYC + 1 + DW * SET_CYC;
  localparam int LAT      = 1 + NCONV * CONV_CYC + 1;

  logic           clk;
  logic           srst;
  logic           scan_en;
  logic [NCH-1:0] ch_en;
  logic           req_vld;
  logic [4:0]     req_ch;
  logic           req_ack;
  logic           comp_i;
  logic [NCH-1:0] dac_sel;
  logic           sh_rst;
  logic           sh_hold;
  logic           dac_en;
  logic [DW-1:0]  dac_code;
  logic           res_vld;
  logic [4:0]     res_ch;
  logic [DW-1:0]  res_dat;
  logic           res_os;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  // Analog side: input voltage already divided to DAC units, comparator high when input > DAC.
  int vin = 0;
  assign comp_i = (vin > int'(dac_code));

  int cyc = 0;
  int rr_m = 0;
  bit in_conv = 0;
  bit post_done = 0;
  int cur_ch = 0;
  bit cur_os = 0;
  int cur_vin = 0;
  int sel_cyc = 0;
  int nres = 0;
  bit rand_vin = 0;
  int vin_fix = 0;

  adc_scan_ctl dut (
    .clk      (clk),
    .srst     (srst),
    .scan_en  (scan_en),
    .ch_en    (ch_en),
    .req_vld  (req_vld),
    .req_ch   (req_ch),
    .req_ack  (req_ack),
    .comp_i   (comp_i),
    .dac_sel  (dac_sel),
    .sh_rst   (sh_rst),
    .sh_hold  (sh_hold),
    .dac_en   (dac_en),
    .dac_code (dac_code),
    .res_vld  (res_vld),
    .res_ch   (res_ch),
    .res_dat  (res_dat),
    .res_os   (res_os),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Binary search with a strict compare settles on the largest code below the input.
  function automatic int expected_code(input int v);
    if (v <= 0) return 0;
    if (v - 1 > (1 << DW) - 1) return (1 << DW) - 1;
    return v - 1;
  endfunction

  task automatic predict(output bit v, output int ch, output bit os);
    int c;
    v = 0; ch = 0; os = 0;
    if (req_vld && (int'(req_ch) < NCH)) begin
      v = 1; ch = int'(req_ch); os = 1;
    end else if (scan_en && (ch_en != '0)) begin
      for (int k = 0; k < NCH; k++) begin
        c = (rr_m + k) % NCH;
        if (!v && ch_en[5'(c)]) begin
          v = 1; ch = c;
        end
      end
    end
  endtask

  task automatic checkOutput();
    bit pv, pos, just_sel;
    int pch, d, off;
    just_sel = 0;
    if (srst) begin
      chk("rst_busy", busy, 0);
      chk("rst_dac_sel", dac_sel, 0);
      chk("rst_dac_en", dac_en, 0);
      chk("rst_dac_code", dac_code, 0);
      chk("rst_sh_rst", sh_rst, 0);
      chk("rst_sh_hold", sh_hold, 0);
      chk("rst_res_vld", res_vld, 0);
      chk("rst_res_dat", res_dat, 0);
      chk("rst_res_ch", res_ch, 0);
      chk("rst_res_os", res_os, 0);
      chk("rst_req_ack", req_ack, 0);
      rr_m = 0; in_conv = 0; post_done = 0;
      return;
    end
    if (post_done) begin
      post_done = 0;
      chk("done_idle_busy", busy, 0);
      chk("done_idle_dac_sel", dac_sel, 0);
      chk("done_idle_res_vld", res_vld, 0);
    end else if (!in_conv) begin
      predict(pv, pch, pos);
      chk("sel_busy", busy, 32'(pv));
      if (pv) begin
        in_conv = 1; just_sel = 1; cur_ch = pch; cur_os = pos; sel_cyc = cyc;
        cur_vin = rand_vin ? int'($urandom_range(0, 1100)) : vin_fix;
        vin = cur_vin;
        if (pos) req_vld = 1'b0;
      end else begin
        chk("idle_res_vld", res_vld, 0);
        chk("idle_dac_sel", dac_sel, 0);
      end
    end
    chk("req_ack", req_ack, 32'(just_sel && cur_os));
    if (in_conv) begin
      d = cyc - sel_cyc;
      if (res_vld) begin
        chk("res_ch", res_ch, cur_ch);
        chk("res_os", res_os, 32'(cur_os));
        chk("res_dat", res_dat, expected_code(cur_vin));
        chk("latency", d + 1, LAT);
        chk("done_dac_sel", dac_sel, 0);
        chk("done_dac_en", dac_en, 0);
        chk("done_sh_hold", sh_hold, 0);
        if (!cur_os) rr_m = (cur_ch + 1) % NCH;
        in_conv = 0; post_done = 1; nres++;
      end else if (d >= LAT) begin
        chk("conv_timeout", d, LAT - 1);
        in_conv = 0;
      end else begin
        off = (d - 1) % CONV_CYC;
        chk("conv_dac_sel", dac_sel, 32'(1) << cur_ch);
        chk("conv_dac_en", dac_en, 1);
        chk("conv_busy", busy, 1);
        chk("conv_sh_rst", sh_rst, 32'(d >= 1 && off < RST_CYC));
        chk("conv_sh_hold", sh_hold, 32'(d >= 1 && off >= RST_CYC + TRK_CYC));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic se, input logic [NCH-1:0] ce,
                               input logic rv, input logic [4:0] rc);
    scan_en = se; ch_en = ce; req_vld = rv; req_ch = rc;
  endtask

  task automatic run_results(input int n);
    int target, k, budget;
    target = nres + n; k = 0; budget = n * (LAT + 4) + 4;
    while (nres < target && k < budget) begin
      tick();
      k++;
    end
    if (nres < target) chk("result_timeout", nres, target);
  endtask

  task automatic wait_mid(input int dd);
    int k;
    k = 0;
    while (!(in_conv && (cyc - sel_cyc) >= dd) && k < 2 * LAT + 8) begin
      tick();
      k++;
    end
    if (!(in_conv && (cyc - sel_cyc) >= dd)) chk("wait_mid_timeout", 0, 1);
  endtask

  initial begin
    srst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 5'd0);
    repeat (3) tick();
    srst = 1'b0;

    // Two-channel alternating scan with a fixed mid-range input.
    rand_vin = 0; vin_fix = 600;
    applyStimulus(1'b1, 18'h00003, 1'b0, 5'd0);
    run_results(4);

    // Out-of-range request is ignored; a valid one waits for the running conversion.
    applyStimulus(1'b1, 18'h3FFFF, 1'b1, 5'd25);
    run_results(2);
    wait_mid(20);
    applyStimulus(1'b1, 18'h3FFFF, 1'b1, 5'd7);
    run_results(3);

    // Wrap from channel 17 back to 0.
    applyStimulus(1'b1, 18'h20001, 1'b0, 5'd0);
    run_results(4);

    // Reset in the middle of bit conversion, then restart from channel 0.
    applyStimulus(1'b1, 18'h3FFFF, 1'b0, 5'd0);
    wait_mid(30);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    run_results(2);

    // Comparator stuck high and stuck low.
    vin_fix = 5000;
    run_results(2);
    vin_fix = 0;
    run_results(2);

    // Random inputs, masks and requests.
    rand_vin = 1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, NCH'($urandom_range(1, (1 << NCH) - 1)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 20)));
      run_results(1);
    end

    // Empty mask keeps the controller idle.
    applyStimulus(1'b1, '0, 1'b0, 5'd0);
    repeat (LAT + 10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
